// File: rtl/mc_controller.sv
// mc_controller: main control FSM for the multicycle MIPS datapath.
// Moore decode of a 4-bit state register; pcen is the only output that also
// depends on the current-cycle ALU zero flag.
// Optional macro MC_EXT_OPS_EN adds bne, andi and ori support.
module mc_controller #(
  parameter logic [31:0] PC_START = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  // The controller never drives the PC value; the start address only has to
  // be word aligned for the datapath's fetch to make sense.
  if (PC_START[1:0] != 2'b00) begin : g_pc_start_check
    $error("mc_controller: PC_START must be word aligned");
  end

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_EXT_OPS_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_LOGIEX  = 4'd12
  } state_t;

  state_t     state_reg;
  state_t     state_next;

  logic       iord_dec;
  logic       irwrite_dec;
  logic       memwrite_dec;
  logic       pcwrite_dec;
  logic       branch_dec;
  logic       regwrite_dec;
  logic       regdst_dec;
  logic       memtoreg_dec;
  logic       alusrca_dec;
  logic [1:0] alusrcb_dec;
  logic [1:0] pcsrc_dec;
  logic [2:0] alucontrol_dec;
  logic       illegal_dec;
  logic       branch_cond;
  logic       pcen_dec;

  // State register; reset aborts any instruction and parks in FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Per-state output decode and next-state selection.
  always_comb begin
    state_next     = S_FETCH;
    iord_dec       = 1'b0;
    irwrite_dec    = 1'b0;
    memwrite_dec   = 1'b0;
    pcwrite_dec    = 1'b0;
    branch_dec     = 1'b0;
    regwrite_dec   = 1'b0;
    regdst_dec     = 1'b0;
    memtoreg_dec   = 1'b0;
    alusrca_dec    = 1'b0;
    alusrcb_dec    = 2'b00;
    pcsrc_dec      = 2'b00;
    alucontrol_dec = 3'b000;
    illegal_dec    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        irwrite_dec    = 1'b1;
        alusrcb_dec    = 2'b01;
        alucontrol_dec = ALU_ADD;
        pcwrite_dec    = 1'b1;
        state_next     = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed into aluout while the op is decoded.
        alusrcb_dec    = 2'b11;
        alucontrol_dec = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
`ifdef MC_EXT_OPS_EN
          OP_BNE:           state_next = S_BRANCH;
          OP_ANDI, OP_ORI:  state_next = S_LOGIEX;
`endif
          default: begin
            illegal_dec = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_dec    = 1'b1;
        alusrcb_dec    = 2'b10;
        alucontrol_dec = ALU_ADD;
        state_next     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_dec   = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_dec = 1'b1;
        memtoreg_dec = 1'b1;
      end
      S_MEMWR: begin
        iord_dec     = 1'b1;
        memwrite_dec = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_dec = 1'b1;
        state_next  = S_ALUWB;
        case (funct)
          6'b100000: alucontrol_dec = ALU_ADD;
          6'b100010: alucontrol_dec = ALU_SUB;
          6'b100100: alucontrol_dec = ALU_AND;
          6'b100101: alucontrol_dec = ALU_OR;
          6'b101010: alucontrol_dec = ALU_SLT;
          default: begin
            // Unsupported funct: flag it and skip the write-back.
            alucontrol_dec = ALU_ADD;
            illegal_dec    = 1'b1;
            state_next     = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        regwrite_dec = 1'b1;
        regdst_dec   = 1'b1;
      end
      S_BRANCH: begin
        alusrca_dec    = 1'b1;
        alucontrol_dec = ALU_SUB;
        branch_dec     = 1'b1;
        pcsrc_dec      = 2'b01;
      end
      S_ADDIEX: begin
        alusrca_dec    = 1'b1;
        alusrcb_dec    = 2'b10;
        alucontrol_dec = ALU_ADD;
        state_next     = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_dec = 1'b1;
      end
      S_JUMP: begin
        pcsrc_dec   = 2'b10;
        pcwrite_dec = 1'b1;
      end
`ifdef MC_EXT_OPS_EN
      S_LOGIEX: begin
        alusrca_dec    = 1'b1;
        alusrcb_dec    = 2'b10;
        alucontrol_dec = (op == OP_ORI) ? ALU_OR : ALU_AND;
        state_next     = S_ADDIWB;
      end
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // bne reuses the BRANCH state with the zero test inverted.
`ifdef MC_EXT_OPS_EN
  assign branch_cond = (op == OP_BNE) ? ~zero : zero;
`else
  assign branch_cond = zero;
`endif

  assign pcen_dec = pcwrite_dec | (branch_dec & branch_cond);

  // Every output is held low while reset is asserted, including the
  // instant it rises in the middle of a memory write.
  assign iord       = ~reset & iord_dec;
  assign irwrite    = ~reset & irwrite_dec;
  assign memwrite   = ~reset & memwrite_dec;
  assign pcen       = ~reset & pcen_dec;
  assign regwrite   = ~reset & regwrite_dec;
  assign regdst     = ~reset & regdst_dec;
  assign memtoreg   = ~reset & memtoreg_dec;
  assign alusrca    = ~reset & alusrca_dec;
  assign alusrcb    = reset ? 2'b00 : alusrcb_dec;
  assign pcsrc      = reset ? 2'b00 : pcsrc_dec;
  assign alucontrol = reset ? 3'b000 : alucontrol_dec;
  assign illegal    = ~reset & illegal_dec;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed stimulus with a per-cycle expected-output
// scoreboard; a negedge monitor pops and compares the packed control word.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, irwrite, memwrite, pcen, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed order: iord irwrite memwrite pcen regwrite regdst memtoreg alusrca
  //               alusrcb[1:0] pcsrc[1:0] alucontrol[2:0] illegal
  logic [16:0] act;
  assign act = {iord, irwrite, memwrite, pcen, regwrite, regdst, memtoreg,
                alusrca, alusrcb, pcsrc, alucontrol, illegal};

  localparam logic [16:0] V_ZERO    = 17'h0;
  localparam logic [16:0] V_FETCH   = {8'b0101_0000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] V_DECODE  = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] V_DEC_ILL = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1};
  localparam logic [16:0] V_MEMADR  = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] V_MEMRD   = {8'b1000_0000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] V_MEMWB   = {8'b0000_1010, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] V_MEMWR   = {8'b1010_0000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] V_EXE_ILL = {8'b0000_0001, 2'b00, 2'b00, 3'b010, 1'b1};
  localparam logic [16:0] V_ALUWB   = {8'b0000_1100, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] V_ADDIWB  = {8'b0000_1000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] V_JUMP    = {8'b0001_0000, 2'b00, 2'b10, 3'b000, 1'b0};

  function automatic logic [16:0] v_exec(input logic [2:0] ac);
    return {8'b0000_0001, 2'b00, 2'b00, ac, 1'b0};
  endfunction

  function automatic logic [16:0] v_branch(input logic pe);
    return {3'b000, pe, 4'b0001, 2'b00, 2'b01, 3'b110, 1'b0};
  endfunction

  typedef struct {
    logic [16:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: one expected word per clock cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got=%05h want=%05h", e.tag, act, e.v);
        end else begin
          $display("ok   %s: %05h", e.tag, act);
        end
        total++;
        if (memwrite && irwrite) begin
          bad++;
          $display("FAIL excl_%s: got memwrite=%0b irwrite=%0b want not both 1",
                   e.tag, memwrite, irwrite);
        end
      end
    end
  end

  // Push the expectation for the current cycle, then advance one clock.
  task automatic step(input logic [16:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic begin_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input string name);
    op    = o;
    funct = f;
    zero  = z;
    step(V_FETCH, {name, "_fetch"});
  endtask

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [5:0] fn_tab [5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  logic [2:0] ac_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    reset = 1'b1;
    op    = 6'd0;
    funct = 6'd0;
    zero  = 1'b0;
    @(posedge clk);
    #1;
    // Reset held three cycles: everything low.
    for (int i = 0; i < 3; i++) step(V_ZERO, "reset");
    reset = 1'b0;

    // lw (zero high to show pcen ignores it outside BRANCH)
    begin_instr(6'b100011, 6'd0, 1'b1, "lw");
    step(V_DECODE, "lw_decode");
    step(V_MEMADR, "lw_memadr");
    step(V_MEMRD,  "lw_memrd");
    step(V_MEMWB,  "lw_memwb");

    // sw
    begin_instr(6'b101011, 6'd0, 1'b0, "sw");
    step(V_DECODE, "sw_decode");
    step(V_MEMADR, "sw_memadr");
    step(V_MEMWR,  "sw_memwr");

    // R-type, every supported funct
    for (int i = 0; i < 5; i++) begin
      begin_instr(6'b000000, fn_tab[i], 1'b0, "rtype");
      step(V_DECODE, "rtype_decode");
      step(v_exec(ac_tab[i]), "rtype_execute");
      step(V_ALUWB, "rtype_aluwb");
    end

    // R-type with unsupported funct: illegal in EXECUTE, no write-back
    begin_instr(6'b000000, 6'b000000, 1'b0, "rbad");
    step(V_DECODE,  "rbad_decode");
    step(V_EXE_ILL, "rbad_execute");

    // addi
    begin_instr(6'b001000, 6'd0, 1'b0, "addi");
    step(V_DECODE, "addi_decode");
    step(V_MEMADR, "addi_addiex");
    step(V_ADDIWB, "addi_addiwb");

    // beq taken / not taken
    begin_instr(6'b000100, 6'd0, 1'b1, "beq_t");
    step(V_DECODE, "beq_t_decode");
    step(v_branch(1'b1), "beq_t_branch");
    begin_instr(6'b000100, 6'd0, 1'b0, "beq_n");
    step(V_DECODE, "beq_n_decode");
    step(v_branch(1'b0), "beq_n_branch");

    // j
    begin_instr(6'b000010, 6'd0, 1'b0, "j");
    step(V_DECODE, "j_decode");
    step(V_JUMP,   "j_jump");

    // illegal opcode
    begin_instr(6'b111111, 6'd0, 1'b0, "ill");
    step(V_DEC_ILL, "ill_decode");

    // andi / bne: extended ops only when the option is built in
`ifdef MC_EXT_OPS_EN
    begin_instr(6'b001100, 6'd0, 1'b0, "andi");
    step(V_DECODE, "andi_decode");
    step({8'b0000_0001, 2'b10, 2'b00, 3'b000, 1'b0}, "andi_logiex");
    step(V_ADDIWB, "andi_addiwb");
    begin_instr(6'b000101, 6'd0, 1'b0, "bne");
    step(V_DECODE, "bne_decode");
    step(v_branch(1'b1), "bne_branch");
`else
    begin_instr(6'b001100, 6'd0, 1'b0, "andi");
    step(V_DEC_ILL, "andi_decode");
    begin_instr(6'b000101, 6'd0, 1'b0, "bne");
    step(V_DEC_ILL, "bne_decode");
`endif

    // sw aborted by an asynchronous reset in the MEMWR cycle
    begin_instr(6'b101011, 6'd0, 1'b0, "swrst");
    step(V_DECODE, "swrst_decode");
    step(V_MEMADR, "swrst_memadr");
    #1;
    reset = 1'b1;
    step(V_ZERO, "swrst_abort");
    reset = 1'b0;

    // resumes cleanly in FETCH
    begin_instr(6'b000010, 6'd0, 1'b0, "j2");
    step(V_DECODE, "j2_decode");
    step(V_JUMP,   "j2_jump");

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
